// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding for the generated ALU ports and the
// issuer FSM state encoding.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ROL = 4'd0;
  localparam logic [ALU_OP_W-1:0] ROR = 4'd1;
  localparam logic [ALU_OP_W-1:0] MAX = 4'd2;
  localparam logic [ALU_OP_W-1:0] MIN = 4'd3;
  localparam logic [ALU_OP_W-1:0] MUL = 4'd4;
  localparam logic [ALU_OP_W-1:0] SNE = 4'd5;
  localparam logic [ALU_OP_W-1:0] SLL = 4'd6;
  localparam logic [ALU_OP_W-1:0] SGT = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; no pass-through when full.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues tagged ALU commands, drives one at a time onto a combinational ALU and
// returns captured result/flags in order on a valid/ready response stream.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 5,
  parameter int OPW   = ALU_OP_W,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_shift,
  input  logic [TAGW-1:0]  cmd_tag,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryFlag,
  input  logic             alu_zeroFlag,
  input  logic             alu_signFlag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic             rsp_err,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             busy
);

  localparam int FW = OPW + 2*WIDTH + SHW + TAGW;
  localparam int CW = $clog2(DEPTH) + 1;

  issuer_state_t    r_state;
  issuer_state_t    w_next_state;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [FW-1:0]    w_fifo_dout;
  logic [OPW-1:0]   w_head_op;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic [SHW-1:0]   w_head_sh;
  logic [TAGW-1:0]  w_head_tag;
  logic [TAGW-1:0]  r_tag;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign busy      = (r_state != IDLE) || (w_count != '0);
  assign {w_head_op, w_head_a, w_head_b, w_head_sh, w_head_tag} = w_fifo_dout;

  alu_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // A new op is popped from IDLE, or from HOLD in the same edge the consumer
  // takes the current response, giving one op every two cycles.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = DRIVE;
        end
      end
      DRIVE: w_next_state = HOLD;
      HOLD: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = DRIVE;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      r_tag          <= '0;
    end else if (w_pop) begin
      alu_opcode     <= w_head_op;
      alu_input1     <= w_head_a;
      alu_input2     <= w_head_b;
      alu_shiftValue <= w_head_sh;
      r_tag          <= w_head_tag;
    end
  end

  // The ALU is combinational; its outputs have settled by the end of DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_sign   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else if (r_state == DRIVE) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_carry  <= alu_carryFlag;
      rsp_zero   <= alu_zeroFlag;
      rsp_sign   <= alu_signFlag;
      rsp_err    <= alu_opcode[OPW-1];
      rsp_tag    <= r_tag;
    end else if (r_state == HOLD && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
